// File: rtl/mini_alu_pkg.sv
// Shared definitions for the two-requester mini-ALU arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mini_alu_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CNT_W = 8;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mini_alu_core.sv
// Combinational mini-ALU: ADD/SUB/AND/OR with two's-complement signed overflow flag.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller registers the result.
// Ports: i_op operation, i_a/i_b operands, o_r result (mod 2^WIDTH), o_ovf signed overflow (ADD/SUB only).
module mini_alu_core
    import mini_alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  alu_op_e          i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_r,
    output logic             o_ovf
);

    localparam int MSB = WIDTH - 1;

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;

    assign w_sum  = i_a + i_b;
    assign w_diff = i_a - i_b;

    always_comb begin
        o_r   = '0;
        o_ovf = 1'b0;
        case (i_op)
            OP_ADD: begin
                o_r   = w_sum;
                // Like-signed operands whose sum flips sign have overflowed.
                o_ovf = (i_a[MSB] == i_b[MSB]) && (w_sum[MSB] != i_a[MSB]);
            end
            OP_SUB: begin
                // Opposite-signed operands whose difference loses a's sign have overflowed.
                o_r   = w_diff;
                o_ovf = (i_a[MSB] != i_b[MSB]) && (w_diff[MSB] != i_a[MSB]);
            end
            OP_AND: o_r = i_a & i_b;
            OP_OR:  o_r = i_a | i_b;
            default: begin
                o_r   = '0;
                o_ovf = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mini_alu_arbiter.sv
// Round-robin arbiter sharing one mini-ALU between two requesters, one op in flight, saturating overflow counter.
// Latency: accept edge k -> res_valid high after edge k+1; minimum issue interval 3 cycles.
// Backpressure: result held stable in DONE until res_ready; no request is accepted while an op is in flight.
// Ports: clk/rst_n; req{0,1}_valid/_ready/_op/_a/_b request ports; res_valid/_ready/_data/_ovf/_id result port;
//        ovf_cnt overflow event count, ovf_clr synchronous clear (wins over a same-edge increment).
module mini_alu_arbiter
    import mini_alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_ovf,
    output logic             res_id,
    output logic [CNT_W-1:0] ovf_cnt,
    input  logic             ovf_clr
);

    arb_state_e       r_state;
    arb_state_e       w_state_nxt;
    logic             r_last_grant;
    alu_op_e          r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res_data;
    logic             r_res_ovf;
    logic             r_res_id;
    logic [CNT_W-1:0] r_ovf_cnt;

    logic             w_grant;
    logic             w_grant_id;
    logic [WIDTH-1:0] w_alu_r;
    logic             w_alu_ovf;

    // Winner: with both valid, the one not served last; otherwise the only valid one.
    always_comb begin
        if (req0_valid && req1_valid) begin
            w_grant_id = ~r_last_grant;
        end else begin
            w_grant_id = ~req0_valid;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // rst_n gating keeps ready low while reset is asserted.
                if ((req0_valid || req1_valid) && rst_n) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: w_state_nxt = ST_DONE;
            ST_DONE: begin
                if (res_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign req0_ready = w_grant && !w_grant_id;
    assign req1_ready = w_grant && w_grant_id;

    mini_alu_core #(.WIDTH(WIDTH)) u_core (
        .i_op  (r_op),
        .i_a   (r_a),
        .i_b   (r_b),
        .o_r   (w_alu_r),
        .o_ovf (w_alu_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
            r_op         <= OP_ADD;
            r_a          <= '0;
            r_b          <= '0;
            r_res_id     <= 1'b0;
            r_res_data   <= '0;
            r_res_ovf    <= 1'b0;
        end else begin
            if (w_grant) begin
                r_op         <= alu_op_e'(w_grant_id ? req1_op : req0_op);
                r_a          <= w_grant_id ? req1_a : req0_a;
                r_b          <= w_grant_id ? req1_b : req0_b;
                r_res_id     <= w_grant_id;
                r_last_grant <= w_grant_id;
            end
            if (r_state == ST_EXEC) begin
                r_res_data <= w_alu_r;
                r_res_ovf  <= w_alu_ovf;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_cnt <= '0;
        end else if (ovf_clr) begin
            r_ovf_cnt <= '0;
        end else if ((r_state == ST_EXEC) && w_alu_ovf && (r_ovf_cnt != {CNT_W{1'b1}})) begin
            r_ovf_cnt <= r_ovf_cnt + 1'b1;
        end
    end

    assign res_valid = (r_state == ST_DONE);
    assign res_data  = r_res_data;
    assign res_ovf   = r_res_ovf;
    assign res_id    = r_res_id;
    assign ovf_cnt   = r_ovf_cnt;

endmodule
